// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
// Groups the producer/consumer side of sync_fifo_param into one bundle.
//   write, data_in  : write request and its data (driven by master)
//   read            : read (pop) request (driven by master)
//   data_out        : read data (driven by the FIFO)
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow, underflow : one-cycle error pulses
// master = the logic using the FIFO, slave = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write, data_in, read,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  write, data_in, read,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, overflow/underflow pulses and optional first-word-fall-through.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_param_if.slave (write/data_in/read in, data/status out)
//
// Handshake: write and read are requests. A write is accepted when write=1
// and full=0 before the edge; a read is accepted when read=1 and empty=0
// before the edge. Rejected requests have no effect other than raising
// overflow/underflow for the cycle after the edge.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_w, empty_w;
  logic                  wr_acc, rd_acc;

  // Status comes from the registered count only.
  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  assign wr_acc = bus.write & ~full_w;
  assign rd_acc = bus.read  & ~empty_w;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = bus.write & full_w;
    underflow_d = bus.read  & empty_w;
    // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is always visible; forced to zero while empty.
      assign bus.data_out = empty_w ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
      end
      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
